hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have the following ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID
- idex_rt  in  5  destination of the load in EX
- idex_dREN  in  1  instruction in EX is a load
- exmem_dREN, exmem_dWEN  in  1 each  data access pending in MEM
- exmem_halt  in  1  halt reached MEM
- br_taken  in  1  branch or jump resolved taken in EX
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage-register update enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  bubble-insert strobes; idex_flush drives the ID/EX register flush input
- halt  out  1  sticky processor halt
- state  out  3  current FSM state
- stall_cnt, flush_cnt  out  32 each  performance counters

Function
REQ-002 The FSM states SHALL be RUN, LDSTALL, MEMWAIT, FLUSH and HALTED.
REQ-003 Enables and flushes SHALL be combinational from the current state and inputs, with zero-cycle latency; state, halt and counters SHALL be registered.
REQ-004 Memory wait SHALL apply when exmem_dREN or exmem_dWEN is high and dhit is low: all enables 0, memwb_flush=1, next state MEMWAIT.
REQ-005 MEMWAIT SHALL hold the memory-wait outputs until dhit=1; in that dhit cycle it SHALL assert exmem_en=memwb_en=1 and flushes 0, then return to RUN.
REQ-006 A load-use hazard SHALL be defined as idex_dREN=1, idex_rt!=0, and idex_rt equal to ifid_rs or ifid_rt.
REQ-007 In RUN, a load-use hazard with ihit=1 and no memory wait SHALL produce pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1 and next state LDSTALL.
REQ-008 LDSTALL SHALL last exactly one ihit cycle with normal enables and load-use detection suppressed, then return to RUN.
REQ-009 br_taken=1 with ihit=1 and no memory wait SHALL produce ifid_flush=1, idex_flush=1, all enables 1 and next state FLUSH.
REQ-010 Branch flush SHALL take priority over load-use.
REQ-011 FLUSH SHALL last one ihit cycle with load-use detection suppressed, then return to RUN.
REQ-012 Input priority SHALL be exmem_halt > memory wait > br_taken > load-use.
REQ-013 exmem_halt=1 in any state SHALL set halt=1 and move to HALTED; HALTED SHALL be left only by reset, with all enables 0 and flushes 0.
REQ-014 When ihit=0 outside MEMWAIT and HALTED, the block SHALL drive pc_en=ifid_en=idex_en=0 and exmem_en=memwb_en=1, and the state SHALL NOT advance.
REQ-015 stall_cnt SHALL increment on every cycle with pc_en=0 while the state is not HALTED.
REQ-016 flush_cnt SHALL increment on each cycle where ifid_flush or idex_flush is asserted.
REQ-017 Both counters SHALL saturate at 0xFFFF_FFFF with no wrap.
REQ-018 When the state is not HALTED and no rule in REQ-004 to REQ-014 applies, all enables SHALL be 1 and all flushes 0.

Reset
REQ-019 When nRST=0 the block SHALL immediately force state=RUN, halt=0, stall_cnt=0 and flush_cnt=0, including mid-MEMWAIT or in HALTED.
REQ-020 While nRST=0 all enables SHALL be 0 and all flushes SHALL be 0.

Structure
REQ-021 The state enum hzd_state_t, word_t and regbits_t SHALL be defined in cpu_types_pkg.
REQ-022 The counters SHALL be two instances of the sub-module sat_counter (32-bit, enable input, saturating).
REQ-023 The RTL SHALL contain no other sub-modules.

Verification
REQ-024 The bench SHALL apply idex_dREN=1, idex_rt=5, ifid_rs=5, ihit=1 -> exactly one cycle of pc_en=0 and idex_flush=1, state RUN->LDSTALL->RUN, stall_cnt=1.
REQ-025 The bench SHALL apply the load-use case with idex_rt=0 -> no stall and stall_cnt=0.
REQ-026 The bench SHALL apply br_taken=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_en=1, state FLUSH, flush_cnt=1, no LDSTALL.
REQ-027 The bench SHALL apply exmem_dREN=1 with dhit low for 3 cycles -> all enables 0 for 3 cycles, dhit cycle exmem_en=1, stall_cnt=4 including the dhit cycle.
REQ-028 The bench SHALL apply exmem_halt=1 during MEMWAIT -> HALTED and halt=1, then nRST pulse -> RUN with counters 0.
REQ-029 The bench SHALL preload stall_cnt to 0xFFFF_FFFE by force and stall 3 cycles -> the value holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipeline hazard controller.
//   word_t      : 32-bit datapath / counter word
//   regbits_t   : 5-bit architectural register index
//   hzd_state_t : hazard controller FSM states
//   hzd_ctrl_t  : bundle of stage enables and bubble strobes, MSB first:
//                 pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//                 ifid_flush, idex_flush, memwb_flush
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        LDSTALL = 3'd1,
        MEMWAIT = 3'd2,
        FLUSH   = 3'd3,
        HALTED  = 3'd4
    } hzd_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } hzd_ctrl_t;

    // Everything frozen, no bubbles: reset and halted behaviour.
    localparam hzd_ctrl_t CTRL_FROZEN  = 8'b00000_000;
    // Every stage advances, no bubbles.
    localparam hzd_ctrl_t CTRL_NORMAL  = 8'b11111_000;
    // Data memory busy: whole pipe frozen, MEM/WB gets a bubble so the
    // stalled access is not written back twice.
    localparam hzd_ctrl_t CTRL_MEMWAIT = 8'b00000_001;
    // Front end holds while the back end drains (fetch miss, or the cycle
    // the data memory finally answers).
    localparam hzd_ctrl_t CTRL_DRAIN   = 8'b00011_000;
    // Taken branch: squash the two wrong-path instructions behind it.
    localparam hzd_ctrl_t CTRL_BRANCH  = 8'b11111_110;
    // Load-use: hold PC and IF/ID, inject a bubble into ID/EX, let the
    // load move on so its data is forwardable next cycle.
    localparam hzd_ctrl_t CTRL_LDUSE   = 8'b00111_010;

    // True when the instruction in ID reads the register the load in EX
    // is about to produce. Register 0 is hardwired and never a hazard.
    function automatic logic load_use_hazard(
        input logic     ex_is_load,
        input regbits_t ex_rt,
        input regbits_t id_rs,
        input regbits_t id_rt
    );
        return ex_is_load && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset, clears the count
//   en    : count one when high
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_reg <= '0;
        end else if (en && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a 5-stage CPU. Produces the stage-register
// enables and bubble strobes combinationally from the current FSM state and
// the hazard inputs; the state, sticky halt and two performance counters are
// registered.
//
// Ports
//   CLK, nRST                   clock (rising) and async active-low reset
//   ihit / dhit                 fetch / data access completes this cycle
//   ifid_rs, ifid_rt            sources of the instruction in ID
//   idex_rt, idex_dREN          destination / load flag of the op in EX
//   exmem_dREN, exmem_dWEN      data access pending in MEM
//   exmem_halt                  halt instruction reached MEM
//   br_taken                    branch/jump resolved taken in EX
//   pc_en .. memwb_en           stage-register update enables
//   ifid_flush, idex_flush,
//   memwb_flush                 bubble-insert strobes
//   halt                        sticky halt
//   state                       current FSM state (hzd_state_t encoding)
//   stall_cnt, flush_cnt        saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  regbits_t   ifid_rs,
    input  regbits_t   ifid_rt,
    input  regbits_t   idex_rt,
    input  logic       idex_dREN,
    input  logic       exmem_dREN,
    input  logic       exmem_dWEN,
    input  logic       exmem_halt,
    input  logic       br_taken,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       memwb_flush,
    output logic       halt,
    output logic [2:0] state,
    output word_t      stall_cnt,
    output word_t      flush_cnt
);

    hzd_state_t state_reg;
    hzd_state_t state_next;
    logic       halt_reg;

    hzd_ctrl_t  ctrl_raw;
    hzd_ctrl_t  ctrl_out;

    logic       mem_wait;
    logic       load_use;
    logic       stall_inc;
    logic       flush_inc;

    // A data access that has not completed holds the whole pipe.
    assign mem_wait = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign load_use = load_use_hazard(idex_dREN, idex_rt, ifid_rs, ifid_rt);

    // -------------------------------------------------------------------------
    // State register and sticky halt
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= RUN;
            halt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            halt_reg  <= halt_reg | exmem_halt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and control outputs
    // Priority: halt > memory wait > fetch miss > branch > load-use.
    // The fetch-miss test sits after memory wait because a stalled data
    // access freezes the back end too, and before branch/load-use because
    // those only act when the fetch stage actually delivers an instruction.
    // -------------------------------------------------------------------------
    always_comb begin
        ctrl_raw   = CTRL_NORMAL;
        state_next = state_reg;

        if ((state_reg == HALTED) || exmem_halt) begin
            ctrl_raw   = CTRL_FROZEN;
            state_next = HALTED;
        end else begin
            case (state_reg)
                MEMWAIT: begin
                    if (dhit) begin
                        // Access completes: let the load/store leave MEM
                        // while the front end still waits one more cycle.
                        ctrl_raw   = CTRL_DRAIN;
                        state_next = RUN;
                    end else begin
                        ctrl_raw   = CTRL_MEMWAIT;
                    end
                end

                RUN, LDSTALL, FLUSH: begin
                    if (mem_wait) begin
                        ctrl_raw   = CTRL_MEMWAIT;
                        state_next = MEMWAIT;
                    end else if (!ihit) begin
                        // Fetch not done: hold front end, keep the state so
                        // the pending one-cycle LDSTALL/FLUSH is not lost.
                        ctrl_raw   = CTRL_DRAIN;
                    end else if (br_taken) begin
                        ctrl_raw   = CTRL_BRANCH;
                        state_next = FLUSH;
                    end else if ((state_reg == RUN) && load_use) begin
                        // Only RUN looks for load-use: in LDSTALL the bubble
                        // is already in EX, in FLUSH the ID op was squashed.
                        ctrl_raw   = CTRL_LDUSE;
                        state_next = LDSTALL;
                    end else begin
                        ctrl_raw   = CTRL_NORMAL;
                        state_next = RUN;
                    end
                end

                default: begin
                    // Unused encodings fall back to RUN with the pipe held.
                    ctrl_raw   = CTRL_FROZEN;
                    state_next = RUN;
                end
            endcase
        end
    end

    // Reset is asynchronous, so the outputs must drop the moment nRST falls
    // rather than waiting for the state register to be cleared.
    assign ctrl_out = nRST ? ctrl_raw : CTRL_FROZEN;

    assign pc_en       = ctrl_out.pc_en;
    assign ifid_en     = ctrl_out.ifid_en;
    assign idex_en     = ctrl_out.idex_en;
    assign exmem_en    = ctrl_out.exmem_en;
    assign memwb_en    = ctrl_out.memwb_en;
    assign ifid_flush  = ctrl_out.ifid_flush;
    assign idex_flush  = ctrl_out.idex_flush;
    assign memwb_flush = ctrl_out.memwb_flush;

    assign halt  = halt_reg;
    assign state = state_reg;

    // -------------------------------------------------------------------------
    // Performance counters
    // A cycle in which the PC does not advance is a stall, except once the
    // processor has halted (that is not lost throughput).
    // -------------------------------------------------------------------------
    assign stall_inc = ~ctrl_out.pc_en & (state_reg != HALTED);
    assign flush_inc = ctrl_out.ifid_flush | ctrl_out.idex_flush;

    sat_counter #(
        .WIDTH (WORD_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (WORD_W)
    ) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a rule-table reference model.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic        idex_dREN, exmem_dREN, exmem_dWEN, exmem_halt, br_taken;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, memwb_flush;
    logic        halt;
    logic [2:0]  state;
    logic [31:0] stall_cnt, flush_cnt;
    logic [7:0]  ctrl_vec;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    hazard_ctrl dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .idex_rt     (idex_rt),
        .idex_dREN   (idex_dREN),
        .exmem_dREN  (exmem_dREN),
        .exmem_dWEN  (exmem_dWEN),
        .exmem_halt  (exmem_halt),
        .br_taken    (br_taken),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .memwb_flush (memwb_flush),
        .halt        (halt),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 CLK = ~CLK;

    assign ctrl_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, memwb_flush};

    // ---------------------------------------------------------------- checker
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Which rule of the hazard policy applies this cycle.
    typedef enum int {
        R_RESET, R_HALT, R_MEMWAIT, R_WAITDONE, R_NOIHIT, R_BRANCH, R_LOADUSE, R_NORMAL
    } rule_t;

    hzd_state_t m_state;
    longint     m_stall;
    longint     m_flush;

    function automatic bit lu_match();
        return idex_dREN && (idex_rt != 5'd0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    endfunction

    function automatic rule_t pick_rule();
        if (!nRST)                                   return R_RESET;
        if (m_state == HALTED || exmem_halt)         return R_HALT;
        if (m_state == MEMWAIT)                      return dhit ? R_WAITDONE : R_MEMWAIT;
        if ((exmem_dREN || exmem_dWEN) && !dhit)     return R_MEMWAIT;
        if (!ihit)                                   return R_NOIHIT;
        if (br_taken)                                return R_BRANCH;
        if (m_state == RUN && lu_match())            return R_LOADUSE;
        return R_NORMAL;
    endfunction

    // Output pattern per rule: {pc, ifid, idex, exmem, memwb, ifidF, idexF, memwbF}
    function automatic logic [7:0] rule_ctrl(input rule_t r);
        case (r)
            R_MEMWAIT:  return 8'b00000_001;
            R_WAITDONE: return 8'b00011_000;
            R_NOIHIT:   return 8'b00011_000;
            R_BRANCH:   return 8'b11111_110;
            R_LOADUSE:  return 8'b00111_010;
            R_NORMAL:   return 8'b11111_000;
            default:    return 8'b00000_000;
        endcase
    endfunction

    task automatic model_reset();
        m_state = RUN;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_advance(input rule_t r, input logic [7:0] c);
        if (r == R_RESET) begin
            model_reset();
            return;
        end
        if (!c[7] && m_state != HALTED && m_stall < 64'hFFFF_FFFF) m_stall++;
        if ((c[2] || c[1]) && m_flush < 64'hFFFF_FFFF)             m_flush++;
        case (r)
            R_HALT:     m_state = HALTED;
            R_MEMWAIT:  m_state = MEMWAIT;
            R_WAITDONE: m_state = RUN;
            R_NOIHIT:   m_state = m_state;
            R_BRANCH:   m_state = FLUSH;
            R_LOADUSE:  m_state = LDSTALL;
            default:    m_state = RUN;
        endcase
    endtask

    // One clock cycle: called at a falling edge with inputs already applied.
    task automatic run_cycle(input string tag);
        rule_t      r;
        logic [7:0] exp;
        #1;
        r   = pick_rule();
        exp = rule_ctrl(r);
        check_val({tag, ".ctrl"},  32'(ctrl_vec),  32'(exp));
        check_val({tag, ".state"}, 32'(state),     32'(m_state));
        check_val({tag, ".halt"},  32'(halt),      32'(m_state == HALTED));
        check_val({tag, ".stall"}, stall_cnt,      m_stall[31:0]);
        check_val({tag, ".flush"}, flush_cnt,      m_flush[31:0]);
        $display("cyc %0d %-6s rule=%0d state=%0d ctrl=%b stall=%0d flush=%0d",
                 cyc, tag, r, state, ctrl_vec, stall_cnt, flush_cnt);
        model_advance(r, exp);
        cyc++;
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0;
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
        idex_dREN = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
        exmem_halt = 1'b0; br_taken = 1'b0;
    endtask

    // Reset asserted at a falling edge; the model clears immediately because
    // the DUT reset is asynchronous and is checked before any rising edge.
    task automatic do_reset();
        nRST = 1'b0;
        model_reset();
        run_cycle("reset");
        nRST = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int halted_cycles;
        nRST = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge CLK);
        run_cycle("por");
        nRST = 1'b1;

        // ---- load-use with a real match: one stall cycle, RUN->LDSTALL->RUN
        idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        run_cycle("lu0");
        check_val("lu.state_ldstall", 32'(state), 32'(LDSTALL));
        run_cycle("lu1");
        check_val("lu.state_run", 32'(state), 32'(RUN));
        idle_inputs();
        run_cycle("lu2");
        check_val("lu.stall_cnt", stall_cnt, 32'd1);

        // ---- load into r0 is never a hazard
        do_reset();
        idex_dREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        run_cycle("r0a");
        run_cycle("r0b");
        check_val("r0.stall_cnt", stall_cnt, 32'd0);
        check_val("r0.state", 32'(state), 32'(RUN));

        // ---- branch beats load-use
        do_reset();
        idex_dREN = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7; br_taken = 1'b1;
        run_cycle("br0");
        check_val("br.state_flush", 32'(state), 32'(FLUSH));
        check_val("br.flush_cnt", flush_cnt, 32'd1);
        br_taken = 1'b0;
        run_cycle("br1");
        check_val("br.no_ldstall", 32'(state), 32'(RUN));
        check_val("br.stall_cnt", stall_cnt, 32'd0);
        idle_inputs();

        // ---- three-cycle data wait, then completion
        do_reset();
        exmem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle("mw");
        check_val("mw.state", 32'(state), 32'(MEMWAIT));
        dhit = 1'b1;
        run_cycle("mwdone");
        idle_inputs();
        check_val("mw.stall_cnt", stall_cnt, 32'd4);
        check_val("mw.state_run", 32'(state), 32'(RUN));

        // ---- halt during a memory wait, then reset recovers
        exmem_dWEN = 1'b1; dhit = 1'b0;
        run_cycle("hw0");
        exmem_halt = 1'b1;
        run_cycle("hw1");
        check_val("hlt.state", 32'(state), 32'(HALTED));
        check_val("hlt.halt", 32'(halt), 32'd1);
        idle_inputs();
        br_taken = 1'b1;
        run_cycle("hw2");
        check_val("hlt.sticky", 32'(halt), 32'd1);
        idle_inputs();
        do_reset();
        check_val("hlt.rst_state", 32'(state), 32'(RUN));
        check_val("hlt.rst_halt", 32'(halt), 32'd0);
        check_val("hlt.rst_stall", stall_cnt, 32'd0);
        check_val("hlt.rst_flush", flush_cnt, 32'd0);

        // ---- stall counter saturation
        idle_inputs();
        force dut.u_stall_cnt.count_reg = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.count_reg;
        m_stall = 64'hFFFF_FFFE;
        run_cycle("sat0");
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle("sat");
        check_val("sat.stall_cnt", stall_cnt, 32'hFFFF_FFFF);
        idle_inputs();

        // ---- random traffic
        do_reset();
        halted_cycles = 0;
        for (int n = 0; n < 400; n++) begin
            ihit       = ($urandom_range(0, 7) != 0);
            dhit       = ($urandom_range(0, 2) == 0);
            exmem_dREN = ($urandom_range(0, 5) == 0);
            exmem_dWEN = ($urandom_range(0, 7) == 0);
            br_taken   = ($urandom_range(0, 5) == 0);
            idex_dREN  = ($urandom_range(0, 1) == 1);
            idex_rt    = 5'($urandom_range(0, 3));
            ifid_rs    = 5'($urandom_range(0, 3));
            ifid_rt    = 5'($urandom_range(0, 3));
            exmem_halt = ($urandom_range(0, 99) == 0);
            if (m_state == HALTED) halted_cycles++;
            if (halted_cycles > 3) begin
                halted_cycles = 0;
                do_reset();
            end else begin
                run_cycle("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
